pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage MIPS32 core. Merges decode load-use

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_if.sv | 29 ++
 rtl/pipe_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall vector layout, stall constants, FSM encodings.
// Also pulled in by the if/id and id/ex pipeline registers.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    // Stall vector bit positions, one per pipeline register
    localparam int STALL_B_PC  = 0;
    localparam int STALL_B_IF  = 1;
    localparam int STALL_B_ID  = 2;
    localparam int STALL_B_EX  = 3;
    localparam int STALL_B_MEM = 4;
    localparam int STALL_B_WB  = 5;

    typedef logic [STALL_W-1:0] stall_t;

    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULTI = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the sequencing controller.
// The controller takes the slave side; the stage logic (or a bench) drives the master side.
interface pipe_ctrl_if #(
    parameter int CNT_W  = 4,
    parameter int PERF_W = 32
);
    logic              id_stallreq;
    logic              ex_mc_start;
    logic [CNT_W-1:0]  ex_mc_len;
    logic              flush_req;
    logic [31:0]       flush_pc;
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              ex_busy;
    logic              mc_done;
    logic              mc_abort;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_stallreq, ex_mc_start, ex_mc_len, flush_req, flush_pc,
        input  stall, flush, new_pc, ex_busy, mc_done, mc_abort, stall_cycles
    );

    modport slave (
        input  id_stallreq, ex_mc_start, ex_mc_len, flush_req, flush_pc,
        output stall, flush, new_pc, ex_busy, mc_done, mc_abort, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst)
            r_value <= '0;
        else if (inc && (r_value != {W{1'b1}}))
            r_value <= r_value + W'(1);
    end

    assign value = r_value;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges load-use stalls, times multi-cycle EX ops,
// and issues single-cycle exception flushes with a redirect PC.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int PERF_W = 32
) (
    input logic         clk,
    input logic         rst,
    pipe_ctrl_if.slave  bus
);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [31:0]      r_new_pc;
    logic             r_mc_done;
    logic             r_mc_abort;
    stall_t           w_stall;

    // State register plus the registered pulses that ride along with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_new_pc   <= '0;
            r_mc_done  <= 1'b0;
            r_mc_abort <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            if (bus.flush_req)
                r_new_pc <= bus.flush_pc;
            r_mc_done  <= (w_nxt_state == ST_MULTI) && (w_nxt_cnt == CNT_W'(1));
            r_mc_abort <= (r_state == ST_MULTI) && bus.flush_req;
        end
    end

    // Next state: a flush request overrides everything, including an op in flight
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    w_nxt_state = ST_FLUSH;
                    w_nxt_cnt   = '0;
                end else if (bus.ex_mc_start && (bus.ex_mc_len != '0)) begin
                    w_nxt_state = ST_MULTI;
                    w_nxt_cnt   = bus.ex_mc_len;
                end
            end
            ST_MULTI: begin
                if (bus.flush_req) begin
                    w_nxt_state = ST_FLUSH;
                    w_nxt_cnt   = '0;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt   = r_cnt - CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                w_nxt_state = bus.flush_req ? ST_FLUSH : ST_IDLE;
                w_nxt_cnt   = '0;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs; everything reads as zero while reset is held, even before the first edge
    always_comb begin
        w_stall = STALL_NONE;
        case (r_state)
            ST_MULTI: w_stall = STALL_EX;
            ST_IDLE:  w_stall = bus.id_stallreq ? STALL_ID : STALL_NONE;
            default:  w_stall = STALL_NONE;
        endcase
        if (rst)
            w_stall = STALL_NONE;

        bus.stall    = w_stall;
        bus.flush    = !rst && (r_state == ST_FLUSH);
        bus.ex_busy  = !rst && (r_state == ST_MULTI);
        bus.mc_done  = !rst && r_mc_done;
        bus.mc_abort = !rst && r_mc_abort;
        bus.new_pc   = rst ? 32'h0 : r_new_pc;
    end

    sat_counter #(
        .W (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall != STALL_NONE),
        .value (bus.stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expectations are queued with the stimulus and
// popped against the DUT; a second narrow-counter instance checks saturation.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(4), .PERF_W(32)) u_if ();
    pipe_ctrl_if #(.CNT_W(4), .PERF_W(4))  u_if2 ();

    pipe_ctrl #(.CNT_W(4), .PERF_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    pipe_ctrl #(.CNT_W(4), .PERF_W(4)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (u_if2)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        busy;
        logic        done;
        logic        abort;
        logic [31:0] npc;
    } exp_t;

    exp_t        q[$];
    int          n_tot = 0;
    int          n_bad = 0;
    logic [31:0] exp_perf = 0;
    string       cur = "";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, queue the expectation, then check it.
    task automatic cyc(input logic r, input logic id, input logic st, input logic [3:0] len,
                       input logic fl, input logic [31:0] pc,
                       input logic [5:0] es, input logic ef, input logic eb,
                       input logic ed, input logic ea, input logic [31:0] epc);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst               = r;
        u_if.id_stallreq  = id;
        u_if.ex_mc_start  = st;
        u_if.ex_mc_len    = len;
        u_if.flush_req    = fl;
        u_if.flush_pc     = pc;
        e.stall = es; e.flush = ef; e.busy = eb; e.done = ed; e.abort = ea; e.npc = epc;
        q.push_back(e);
        #1;
        g = q.pop_front();
        chk({cur, ".stall"}, 32'(u_if.stall),    32'(g.stall));
        chk({cur, ".flush"}, 32'(u_if.flush),    32'(g.flush));
        chk({cur, ".busy"},  32'(u_if.ex_busy),  32'(g.busy));
        chk({cur, ".done"},  32'(u_if.mc_done),  32'(g.done));
        chk({cur, ".abort"}, 32'(u_if.mc_abort), 32'(g.abort));
        if (g.flush)
            chk({cur, ".npc"}, u_if.new_pc, g.npc);
        if (!r)
            chk({cur, ".perf"}, u_if.stall_cycles, exp_perf);
        if (r)
            exp_perf = 0;
        else if (g.stall != 6'b0)
            exp_perf = exp_perf + 1;
    endtask

    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] SI = 6'b000111;
    localparam logic [5:0] SE = 6'b001111;

    initial begin
        rst = 1'b1;
        u_if.id_stallreq = 0; u_if.ex_mc_start = 0; u_if.ex_mc_len = 0;
        u_if.flush_req = 0; u_if.flush_pc = 0;
        u_if2.id_stallreq = 0; u_if2.ex_mc_start = 0; u_if2.ex_mc_len = 0;
        u_if2.flush_req = 0; u_if2.flush_pc = 0;

        // Reset: outputs forced low even with requests asserted
        cur = "rst";
        cyc(1, 1, 1, 4'd3, 1, 32'h1234, S0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 4'd0, 0, 32'h0,    S0, 0, 0, 0, 0, 0);
        cur = "rst_out";
        cyc(0, 0, 0, 4'd0, 0, 32'h0,    S0, 0, 0, 0, 0, 0);
        chk("rst.npc", u_if.new_pc, 32'h0);

        // Load-use stall for two cycles
        cur = "t1";
        cyc(0, 1, 0, 4'd0, 0, 0, SI, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 4'd0, 0, 0, SI, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, S0, 0, 0, 0, 0, 0);
        chk("t1.perf2", u_if.stall_cycles, 32'd2);

        // Multi-cycle op of length 3, with an id_stallreq inside that adds nothing
        cur = "t2";
        cyc(0, 0, 1, 4'd3, 0, 0, S0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 4'd0, 0, 0, SE, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, SE, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, SE, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, S0, 0, 0, 0, 0, 0);

        // Zero-length op is ignored
        cur = "t3";
        cyc(0, 0, 1, 4'd0, 0, 0, S0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, S0, 0, 0, 0, 0, 0);

        // Flush during cycle 2 of a length-5 op
        cur = "t4";
        cyc(0, 0, 1, 4'd5, 0, 0,             S0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0,             SE, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 1, 32'hBFC0_0380, SE, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0,             S0, 1, 0, 0, 1, 32'hBFC0_0380);
        cyc(0, 0, 0, 4'd0, 0, 0,             S0, 0, 0, 0, 0, 0);
        chk("t4.npc_hold", u_if.new_pc, 32'hBFC0_0380);

        // Flush beats a simultaneous load-use request
        cur = "t5";
        cyc(0, 1, 0, 4'd0, 1, 32'h8000_0180, SI, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 4'd0, 0, 0,             S0, 1, 0, 0, 0, 32'h8000_0180);
        cyc(0, 0, 0, 4'd0, 0, 0,             S0, 0, 0, 0, 0, 0);

        // Back-to-back flush re-latches the redirect PC
        cur = "b2b";
        cyc(0, 0, 0, 4'd0, 1, 32'hAAAA_0000, S0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 1, 32'h5555_0004, S0, 1, 0, 0, 0, 32'hAAAA_0000);
        cyc(0, 0, 0, 4'd0, 0, 0,             S0, 1, 0, 0, 0, 32'h5555_0004);
        cyc(0, 0, 0, 4'd0, 0, 0,             S0, 0, 0, 0, 0, 0);

        // Start while busy is ignored
        cur = "restart";
        cyc(0, 0, 1, 4'd2, 0, 0, S0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 4'd7, 0, 0, SE, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, SE, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, S0, 0, 0, 0, 0, 0);

        // Length 1: done in the only busy cycle
        cur = "len1";
        cyc(0, 0, 1, 4'd1, 0, 0, S0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, SE, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, S0, 0, 0, 0, 0, 0);

        // Maximum length 15
        cur = "len15";
        cyc(0, 0, 1, 4'd15, 0, 0, S0, 0, 0, 0, 0, 0);
        for (int i = 15; i >= 1; i--)
            cyc(0, 0, 0, 4'd0, 0, 0, SE, 0, 1, (i == 1), 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, S0, 0, 0, 0, 0, 0);

        // Reset in the middle of an op: no pulses, counters cleared
        cur = "t6";
        cyc(0, 0, 1, 4'd5, 0, 0, S0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, SE, 0, 1, 0, 0, 0);
        cyc(1, 1, 0, 4'd0, 1, 32'hDEAD_BEEF, S0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, S0, 0, 0, 0, 0, 0);
        chk("t6.npc", u_if.new_pc, 32'h0);
        cyc(0, 0, 0, 4'd0, 0, 0, S0, 0, 0, 0, 0, 0);

        // Narrow performance counter saturates at 4'hF
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            u_if2.id_stallreq = 1'b1;
            #1;
            if (i == 14)
                chk("sat.mid", 32'(u_if2.stall_cycles), 32'd14);
        end
        @(negedge clk);
        u_if2.id_stallreq = 1'b0;
        #1;
        chk("sat.full", 32'(u_if2.stall_cycles), 32'hF);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
